trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences entry to and exit from the handler ROM region (word address 0x4000+) of the instruction fetch unit.
//  Latches syscall and IRQ requests, selects one, saves the return PC and drives a one-cycle jump into the handler vector.
//  On eret it drives a one-cycle jump back to the saved PC.
//  Sits between decode/peripherals and the fetch jump inputs; its jump has priority over decoder jumps (merged upstream).
// PARAMETERS
//  NUM_IRQ          4        number of external interrupt lines (1..8)
//  VEC_STRIDE_LOG2  6        log2 words between handler vectors; require (NUM_IRQ+1)<<VEC_STRIDE_LOG2 <= 4096
//  HANDLER_BASE     26'h4000 word address of handler region (pc[14]=1)
// PORTS
//  clk_i         in   1        CPU clock; all state updates on posedge
//  reset_n_i     in   1        asynchronous, active-low reset
//  mode_i        in   4        CPU mode; 5 = run, 6 = reset mode
//  pc_plus4_i    in   32       next sequential word address from fetch
//  syscall_i     in   1        decoder: current instruction is syscall (level, 1 cycle per instr)
//  eret_i        in   1        decoder: current instruction is eret
//  irq_i         in   NUM_IRQ  interrupt lines, rising-edge sensitive
//  mask_wen_i    in   1        write enable for IRQ mask register
//  mask_dat_i    in   NUM_IRQ  new mask (1 = line enabled)
//  j_valid_o     out  1        jump request to fetch, exactly one cycle wide
//  j_addr_o      out  26       jump target word address
//  epc_o         out  32       saved return address
//  cause_o       out  4        0 = syscall, 1+k = irq k
//  in_handler_o  out  1        high while executing handler code
//  irq_ack_o     out  NUM_IRQ  one-cycle pulse when line k is taken
//  mask_o        out  NUM_IRQ  current mask register
// BEHAVIOUR
//  Reset: state IDLE; j_valid_o=0, j_addr_o=0, epc_o=0, cause_o=0, in_handler_o=0, irq_ack_o=0, pending=0, mask=all 1.
//  Edge detect: irq_q <= irq_i; pending |= irq_i & ~irq_q. Taken bit cleared on ack; a new edge in the same cycle wins (stays set).
//  Mask write applies next cycle; a trigger decision in the write cycle uses the old mask. Pending sets regardless of mask.
//  FSM IDLE: if mode_i==5 and (syscall_i or |(pending&mask)):
//   - select syscall first, else lowest-index enabled pending irq
//   - epc_o <= pc_plus4_i; cause_o <= code; irq_ack_o pulses for the taken line; go VECTOR
//   - eret_i in IDLE is ignored.
//  VECTOR (1 cycle): j_valid_o=1, j_addr_o = HANDLER_BASE + (cause_o<<VEC_STRIDE_LOG2); next HANDLER.
//  HANDLER: in_handler_o=1; no nesting, so syscall_i is ignored and irqs stay pending; eret_i -> RETURN.
//  RETURN (1 cycle): j_valid_o=1, j_addr_o=epc_o[25:0], in_handler_o=0; next IDLE. Pending irqs may trigger from IDLE one cycle later.
//  Trigger-to-jump latency: 2 posedges (request sampled, then VECTOR drives jump).
//  j_valid_o is registered, so it is high only in VECTOR/RETURN; j_addr_o holds its last value otherwise.
//  mode_i==6 in any state: next state IDLE, in_handler_o=0, pending cleared, no jump issued; epc/cause/mask retained.
//  mode_i!=5 (and !=6) in IDLE: no trigger; pending keeps accumulating. In VECTOR/RETURN the jump completes regardless.
//  reset_n_i low mid-sequence: immediate return to reset values, including an in-flight j_valid_o.
//  Width: vector arithmetic is 26 bits unsigned; cause zero-extended before the shift.
// STRUCTURE
//  trap_pkg: state enum {IDLE,VECTOR,HANDLER,RETURN}, CAUSE_SYSCALL=4'd0, MODE_RUN=4'd5, MODE_RESET=4'd6.
//  Sub-module irq_pending_arb: edge detect, pending/mask registers, fixed-priority encoder, ack.
//  The top level holds the FSM, epc/cause registers and jump outputs.
// TESTING
//  1 Syscall in IDLE (mode 5, pc_plus4=0x0123) -> next cycle j_valid=1, j_addr=0x4000, cause=0; epc=0x0123; in_handler=1.
//  2 irq[2] edge, mask=4'hF, mode 5 -> irq_ack=4'b0100, cause=3, j_addr=0x40C0; eret -> j_addr=saved epc, in_handler=0.
//  3 irq[1] and irq[3] edges in the same cycle -> irq1 taken first (j_addr=0x4080); after eret, irq3 taken (0x4100) without a new edge.
//  4 mask=4'b1110, irq[0] edge -> no jump; then write mask=4'hF -> irq0 taken, cause=1, j_addr=0x4040.
//  5 Syscall and irq edge while in HANDLER -> no jump until eret; after RETURN, irq serviced; syscall lost.
//  6 mode_i=6 during HANDLER -> IDLE, in_handler=0, no j_valid; reset_n_i low during VECTOR -> j_valid drops immediately.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
// Holds the sequencer state encoding, cause/mode codes and the handler vector
// address helper used by the top-level FSM.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VECTOR  = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  localparam logic [3:0] CAUSE_SYSCALL = 4'd0;
  localparam logic [3:0] MODE_RUN      = 4'd5;
  localparam logic [3:0] MODE_RESET    = 4'd6;

  // Handler entry point: 26-bit unsigned arithmetic, cause zero-extended
  // before the shift so no bits are lost ahead of the add.
  function automatic logic [25:0] vector_addr(
    input logic [25:0] base,
    input logic [3:0]  cause,
    input int unsigned stride_log2
  );
    return base + (26'(cause) << stride_log2);
  endfunction

endpackage

// File: rtl/irq_pending_arb.sv
// IRQ edge detector, pending/mask registers and fixed-priority selector.
// Ports: irq lines in, mask write port, take/flush controls from the FSM;
// req/cause describe the best enabled pending line, ack pulses the taken one.
module irq_pending_arb #(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_wen,
  input  logic [NUM_IRQ-1:0] mask_dat,
  input  logic               take,      // FSM is taking the selected line this cycle
  input  logic               flush,     // drop all pending requests
  output logic               req,
  output logic [3:0]         cause,     // 1 + index of selected line
  output logic [NUM_IRQ-1:0] ack,
  output logic [NUM_IRQ-1:0] mask
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic [NUM_IRQ-1:0] taken;
  logic [2:0]         sel_idx;
  logic               found;

  assign rise     = irq & ~irq_q;
  // Pending lines accumulate regardless of mask; the mask only gates selection.
  assign eligible = pending & mask;
  assign req      = |eligible;
  assign cause    = {1'b0, sel_idx} + 4'd1;
  assign taken    = take ? sel_onehot : '0;

  // Lowest index wins.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!found && eligible[i]) begin
        sel_idx       = i[2:0];
        sel_onehot[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
      ack     <= '0;
    end else begin
      irq_q <= irq;
      // New mask is visible from the next cycle; this cycle's decision used the old one.
      if (mask_wen) begin
        mask <= mask_dat;
      end
      if (flush) begin
        pending <= '0;
        ack     <= '0;
      end else begin
        // A fresh edge on the line being acked keeps it pending.
        pending <= (pending & ~taken) | rise;
        ack     <= taken;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: latches syscall/IRQ, saves return PC, issues
// one-cycle jumps into the handler vector and back on eret.
// Ports: mode/pc/syscall/eret from decode, irq lines and mask write port in;
// j_valid/j_addr to fetch, epc/cause/in_handler/irq_ack/mask status out.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned NUM_IRQ         = 4,
  parameter int unsigned VEC_STRIDE_LOG2 = 6,
  parameter logic [25:0] HANDLER_BASE    = 26'h4000
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [3:0]         mode_i,
  input  logic [31:0]        pc_plus4_i,
  input  logic               syscall_i,
  input  logic               eret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mask_wen_i,
  input  logic [NUM_IRQ-1:0] mask_dat_i,
  output logic               j_valid_o,
  output logic [25:0]        j_addr_o,
  output logic [31:0]        epc_o,
  output logic [3:0]         cause_o,
  output logic               in_handler_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic [NUM_IRQ-1:0] mask_o
);

  state_t     state;
  logic       run_mode;
  logic       flush;
  logic       arb_req;
  logic [3:0] arb_cause;
  logic       trigger;
  logic       take_irq;
  logic [3:0] next_cause;

  assign run_mode   = (mode_i == MODE_RUN);
  assign flush      = (mode_i == MODE_RESET);
  // Only IDLE in run mode may start a trap; handlers do not nest.
  assign trigger    = (state == IDLE) && run_mode && (syscall_i || arb_req);
  // Syscall outranks interrupts, so an IRQ is only consumed when no syscall.
  assign take_irq   = trigger && !syscall_i;
  assign next_cause = syscall_i ? CAUSE_SYSCALL : arb_cause;

  irq_pending_arb #(
    .NUM_IRQ (NUM_IRQ)
  ) u_arb (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .irq      (irq_i),
    .mask_wen (mask_wen_i),
    .mask_dat (mask_dat_i),
    .take     (take_irq),
    .flush    (flush),
    .req      (arb_req),
    .cause    (arb_cause),
    .ack      (irq_ack_o),
    .mask     (mask_o)
  );

  // Outputs are registered alongside the state so j_valid_o is high exactly
  // during VECTOR and RETURN.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      j_valid_o    <= 1'b0;
      j_addr_o     <= '0;
      epc_o        <= '0;
      cause_o      <= '0;
      in_handler_o <= 1'b0;
    end else if (flush) begin
      // Reset mode abandons any sequence; epc/cause are kept for inspection.
      state        <= IDLE;
      j_valid_o    <= 1'b0;
      in_handler_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          j_valid_o <= 1'b0;
          if (trigger) begin
            epc_o     <= pc_plus4_i;
            cause_o   <= next_cause;
            j_valid_o <= 1'b1;
            j_addr_o  <= vector_addr(HANDLER_BASE, next_cause, VEC_STRIDE_LOG2);
            state     <= VECTOR;
          end
        end
        VECTOR: begin
          j_valid_o    <= 1'b0;
          in_handler_o <= 1'b1;
          state        <= HANDLER;
        end
        HANDLER: begin
          if (eret_i) begin
            j_valid_o    <= 1'b1;
            j_addr_o     <= epc_o[25:0];
            in_handler_o <= 1'b0;
            state        <= RETURN;
          end
        end
        RETURN: begin
          j_valid_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  mode = 4'd5;
  logic [31:0] pc = '0;
  logic        syscall = 1'b0;
  logic        eret = 1'b0;
  logic [3:0]  irq = '0;
  logic        mask_wen = 1'b0;
  logic [3:0]  mask_dat = '0;

  logic        j_valid;
  logic [25:0] j_addr;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        in_handler;
  logic [3:0]  irq_ack;
  logic [3:0]  mask;

  int checks = 0;
  int errors = 0;

  trap_sequencer #(
    .NUM_IRQ         (4),
    .VEC_STRIDE_LOG2 (6),
    .HANDLER_BASE    (26'h4000)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .mode_i       (mode),
    .pc_plus4_i   (pc),
    .syscall_i    (syscall),
    .eret_i       (eret),
    .irq_i        (irq),
    .mask_wen_i   (mask_wen),
    .mask_dat_i   (mask_dat),
    .j_valid_o    (j_valid),
    .j_addr_o     (j_addr),
    .epc_o        (epc),
    .cause_o      (cause),
    .in_handler_o (in_handler),
    .irq_ack_o    (irq_ack),
    .mask_o       (mask)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL rst_jvalid got %0b want 0", j_valid); end
    checks++; if (j_addr !== 26'h0) begin errors++; $display("FAIL rst_jaddr got %h want 0", j_addr); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got %h want 0", epc); end
    checks++; if (cause !== 4'd0) begin errors++; $display("FAIL rst_cause got %0d want 0", cause); end
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL rst_inh got %0b want 0", in_handler); end
    checks++; if (irq_ack !== 4'h0) begin errors++; $display("FAIL rst_ack got %b want 0000", irq_ack); end
    checks++; if (mask !== 4'hF) begin errors++; $display("FAIL rst_mask got %h want f", mask); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_jvalid got %0b want 0", j_valid); end
  endtask

  task automatic test_syscall();
    pc = 32'h0000_0123;
    syscall = 1'b1;
    tick();  // VECTOR
    syscall = 1'b0;
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL sys_jvalid got %0b want 1", j_valid); end
    checks++; if (j_addr !== 26'h4000) begin errors++; $display("FAIL sys_jaddr got %h want 4000", j_addr); end
    checks++; if (cause !== 4'd0) begin errors++; $display("FAIL sys_cause got %0d want 0", cause); end
    checks++; if (epc !== 32'h123) begin errors++; $display("FAIL sys_epc got %h want 123", epc); end
    checks++; if (irq_ack !== 4'h0) begin errors++; $display("FAIL sys_ack got %b want 0000", irq_ack); end
    tick();  // HANDLER
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL sys_jvalid_drop got %0b want 0", j_valid); end
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL sys_inh got %0b want 1", in_handler); end
    tick();  // eret ignored-free idle cycle in HANDLER
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL sys_inh_hold got %0b want 1", in_handler); end
    eret = 1'b1;
    tick();  // RETURN
    eret = 1'b0;
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL sys_ret_jvalid got %0b want 1", j_valid); end
    checks++; if (j_addr !== 26'h123) begin errors++; $display("FAIL sys_ret_jaddr got %h want 123", j_addr); end
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL sys_ret_inh got %0b want 0", in_handler); end
    tick();  // IDLE
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL sys_idle_jvalid got %0b want 0", j_valid); end
    checks++; if (j_addr !== 26'h123) begin errors++; $display("FAIL sys_idle_jaddr_hold got %h want 123", j_addr); end
    // eret while idle must not produce a jump
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL idle_eret_jvalid got %0b want 0", j_valid); end
  endtask

  task automatic test_irq_single();
    pc = 32'h0000_0200;
    irq = 4'b0100;
    tick();  // edge captured into pending
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL irq2_early_jvalid got %0b want 0", j_valid); end
    tick();  // VECTOR
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL irq2_jvalid got %0b want 1", j_valid); end
    checks++; if (irq_ack !== 4'b0100) begin errors++; $display("FAIL irq2_ack got %b want 0100", irq_ack); end
    checks++; if (cause !== 4'd3) begin errors++; $display("FAIL irq2_cause got %0d want 3", cause); end
    checks++; if (j_addr !== 26'h40C0) begin errors++; $display("FAIL irq2_jaddr got %h want 40c0", j_addr); end
    checks++; if (epc !== 32'h200) begin errors++; $display("FAIL irq2_epc got %h want 200", epc); end
    tick();  // HANDLER
    checks++; if (irq_ack !== 4'h0) begin errors++; $display("FAIL irq2_ack_pulse got %b want 0000", irq_ack); end
    eret = 1'b1;
    tick();  // RETURN
    eret = 1'b0;
    irq = 4'b0000;
    checks++; if (j_addr !== 26'h200) begin errors++; $display("FAIL irq2_ret_jaddr got %h want 200", j_addr); end
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL irq2_ret_inh got %0b want 0", in_handler); end
    tick();  // IDLE
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL irq2_no_retrigger got %0b want 0", j_valid); end
  endtask

  task automatic test_irq_priority();
    pc = 32'h0000_0300;
    irq = 4'b1010;
    tick();  // both pending
    tick();  // VECTOR for irq1
    checks++; if (j_addr !== 26'h4080) begin errors++; $display("FAIL pri_first_jaddr got %h want 4080", j_addr); end
    checks++; if (irq_ack !== 4'b0010) begin errors++; $display("FAIL pri_first_ack got %b want 0010", irq_ack); end
    tick();  // HANDLER
    eret = 1'b1;
    tick();  // RETURN
    eret = 1'b0;
    tick();  // IDLE
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL pri_idle_jvalid got %0b want 0", j_valid); end
    tick();  // VECTOR for irq3, no new edge
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL pri_second_jvalid got %0b want 1", j_valid); end
    checks++; if (j_addr !== 26'h4100) begin errors++; $display("FAIL pri_second_jaddr got %h want 4100", j_addr); end
    checks++; if (cause !== 4'd4) begin errors++; $display("FAIL pri_second_cause got %0d want 4", cause); end
    checks++; if (irq_ack !== 4'b1000) begin errors++; $display("FAIL pri_second_ack got %b want 1000", irq_ack); end
    tick();  // HANDLER
    eret = 1'b1;
    tick();
    eret = 1'b0;
    irq = 4'b0000;
    tick();
  endtask

  task automatic test_mask();
    mask_wen = 1'b1;
    mask_dat = 4'b1110;
    tick();
    mask_wen = 1'b0;
    checks++; if (mask !== 4'b1110) begin errors++; $display("FAIL mask_write got %b want 1110", mask); end
    pc = 32'h0000_0400;
    irq = 4'b0001;
    tick();
    tick();
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL mask_blocked_jvalid got %0b want 0", j_valid); end
    mask_wen = 1'b1;
    mask_dat = 4'hF;
    tick();  // write cycle still decides with old mask
    mask_wen = 1'b0;
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL mask_write_cycle_jvalid got %0b want 0", j_valid); end
    checks++; if (mask !== 4'hF) begin errors++; $display("FAIL mask_restore got %b want 1111", mask); end
    tick();  // VECTOR
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL mask_jvalid got %0b want 1", j_valid); end
    checks++; if (cause !== 4'd1) begin errors++; $display("FAIL mask_cause got %0d want 1", cause); end
    checks++; if (j_addr !== 26'h4040) begin errors++; $display("FAIL mask_jaddr got %h want 4040", j_addr); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    irq = 4'b0000;
    tick();
  endtask

  task automatic test_no_nesting();
    pc = 32'h0000_0500;
    syscall = 1'b1;
    tick();  // VECTOR
    syscall = 1'b0;
    tick();  // HANDLER
    syscall = 1'b1;
    irq = 4'b0100;
    pc = 32'h0000_0999;
    tick();
    syscall = 1'b0;
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL nest_jvalid got %0b want 0", j_valid); end
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL nest_inh got %0b want 1", in_handler); end
    tick();
    checks++; if (epc !== 32'h500) begin errors++; $display("FAIL nest_epc got %h want 500", epc); end
    eret = 1'b1;
    tick();  // RETURN
    eret = 1'b0;
    checks++; if (j_addr !== 26'h500) begin errors++; $display("FAIL nest_ret_jaddr got %h want 500", j_addr); end
    tick();  // IDLE
    tick();  // VECTOR for held irq2
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL nest_irq_jvalid got %0b want 1", j_valid); end
    checks++; if (cause !== 4'd3) begin errors++; $display("FAIL nest_irq_cause got %0d want 3", cause); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    irq = 4'b0000;
    tick();
    tick();
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL nest_syscall_lost got %0b want 0", j_valid); end
  endtask

  task automatic test_mode_and_reset();
    pc = 32'h0000_0600;
    syscall = 1'b1;
    tick();  // VECTOR
    syscall = 1'b0;
    tick();  // HANDLER
    irq = 4'b0001;
    tick();  // irq0 pending
    mode = 4'd6;
    tick();
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL m6_inh got %0b want 0", in_handler); end
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL m6_jvalid got %0b want 0", j_valid); end
    checks++; if (epc !== 32'h600) begin errors++; $display("FAIL m6_epc got %h want 600", epc); end
    mode = 4'd5;
    irq = 4'b0000;
    tick();
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL m6_pending_cleared got %0b want 0", j_valid); end
    // Non-run mode: requests wait, pending keeps accumulating.
    mode = 4'd2;
    irq = 4'b0010;
    syscall = 1'b1;
    tick();
    syscall = 1'b0;
    tick();
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL mode2_jvalid got %0b want 0", j_valid); end
    mode = 4'd5;
    tick();  // VECTOR for irq1
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL mode2_resume_jvalid got %0b want 1", j_valid); end
    checks++; if (j_addr !== 26'h4080) begin errors++; $display("FAIL mode2_resume_jaddr got %h want 4080", j_addr); end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    irq = 4'b0000;
    tick();
    // Async reset while the vector jump is on the wire.
    pc = 32'h0000_0700;
    syscall = 1'b1;
    tick();
    syscall = 1'b0;
    checks++; if (j_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_jvalid got %0b want 1", j_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL arst_jvalid got %0b want 0", j_valid); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL arst_epc got %h want 0", epc); end
    checks++; if (j_addr !== 26'h0) begin errors++; $display("FAIL arst_jaddr got %h want 0", j_addr); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    tick();
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL arst_inh got %0b want 0", in_handler); end
    checks++; if (j_valid !== 1'b0) begin errors++; $display("FAIL arst_idle_jvalid got %0b want 0", j_valid); end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_irq_single();
    test_irq_priority();
    test_mask();
    test_no_nesting();
    test_mode_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
